// File: rtl/axi_rd_arbiter.sv
// ---------------------------------------------------------------------------
// axi_rd_arbiter
//
// Shares one AXI burst read port between two masters: the icache (master 0)
// and the dcache (master 1). AR requests are arbitrated round-robin. The
// grant is locked from the address handshake until the slave returns rlast.
// The R channel is routed back to the granted master only. Only one
// transaction is outstanding at a time. Beats are counted so that a burst
// whose rlast arrives early or late is flagged on err_len.
//
// Ports
//   clk, rst                   clock, synchronous active-high reset
//   m{0,1}_ar*                 master read-address channels (addr/len/size/burst/valid/ready)
//   m{0,1}_r*                  master read-data channels (data/resp/valid/last/ready)
//   s_ar*                      slave read-address channel
//   s_r*                       slave read-data channel
//   grant                      current owner (0=icache, 1=dcache), meaningful while busy
//   busy                       arbiter is in ADDR or DATA
//   err_len                    one-cycle pulse when the beat count disagrees with arlen
// ---------------------------------------------------------------------------
module axi_rd_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64,
  parameter int LEN_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  // master 0 (icache)
  input  logic [ADDR_W-1:0] m0_araddr,
  input  logic [LEN_W-1:0]  m0_arlen,
  input  logic [2:0]        m0_arsize,
  input  logic [1:0]        m0_arburst,
  input  logic              m0_arvalid,
  output logic              m0_arready,
  output logic [DATA_W-1:0] m0_rdata,
  output logic [1:0]        m0_rresp,
  output logic              m0_rvalid,
  output logic              m0_rlast,
  input  logic              m0_rready,
  // master 1 (dcache)
  input  logic [ADDR_W-1:0] m1_araddr,
  input  logic [LEN_W-1:0]  m1_arlen,
  input  logic [2:0]        m1_arsize,
  input  logic [1:0]        m1_arburst,
  input  logic              m1_arvalid,
  output logic              m1_arready,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [1:0]        m1_rresp,
  output logic              m1_rvalid,
  output logic              m1_rlast,
  input  logic              m1_rready,
  // slave
  output logic [ADDR_W-1:0] s_araddr,
  output logic [LEN_W-1:0]  s_arlen,
  output logic [2:0]        s_arsize,
  output logic [1:0]        s_arburst,
  output logic              s_arvalid,
  input  logic              s_arready,
  input  logic [DATA_W-1:0] s_rdata,
  input  logic [1:0]        s_rresp,
  input  logic              s_rvalid,
  input  logic              s_rlast,
  output logic              s_rready,
  // status
  output logic              grant,
  output logic              busy,
  output logic              err_len
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

  localparam logic [LEN_W-1:0] LEN_ZERO = {LEN_W{1'b0}};
  localparam logic [LEN_W-1:0] LEN_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};

  state_t            state;
  logic              last_grant;
  logic [LEN_W-1:0]  beat_cnt;
  logic [LEN_W-1:0]  len_q;
  logic              ar_hs;
  logic              r_hs;

  assign busy  = (state != IDLE);
  assign ar_hs = s_arvalid & s_arready;
  assign r_hs  = s_rvalid & s_rready;

  // Channel routing. Address and data buses are plain muxes of the granted
  // side so they never float; every valid/ready is forced low while rst is
  // high because the state register only returns to IDLE on the next edge.
  always_comb begin
    s_araddr   = grant ? m1_araddr  : m0_araddr;
    s_arlen    = grant ? m1_arlen   : m0_arlen;
    s_arsize   = grant ? m1_arsize  : m0_arsize;
    s_arburst  = grant ? m1_arburst : m0_arburst;
    m0_rdata   = s_rdata;
    m0_rresp   = s_rresp;
    m1_rdata   = s_rdata;
    m1_rresp   = s_rresp;
    s_arvalid  = 1'b0;
    m0_arready = 1'b0;
    m1_arready = 1'b0;
    s_rready   = 1'b0;
    m0_rvalid  = 1'b0;
    m0_rlast   = 1'b0;
    m1_rvalid  = 1'b0;
    m1_rlast   = 1'b0;
    if (rst) begin
      s_arvalid = 1'b0;
    end else begin
      case (state)
        ADDR: begin
          if (grant) begin
            s_arvalid  = m1_arvalid;
            m1_arready = s_arready;
          end else begin
            s_arvalid  = m0_arvalid;
            m0_arready = s_arready;
          end
        end
        DATA: begin
          if (grant) begin
            s_rready  = m1_rready;
            m1_rvalid = s_rvalid;
            m1_rlast  = s_rlast;
          end else begin
            s_rready  = m0_rready;
            m0_rvalid = s_rvalid;
            m0_rlast  = s_rlast;
          end
        end
        default: begin
          // IDLE: nothing forwarded, stray slave beats are ignored
          s_arvalid = 1'b0;
        end
      endcase
    end
  end

  // Arbitration FSM, burst lock, beat counting and length-error pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      grant      <= 1'b0;
      last_grant <= 1'b1;  // makes m0 win the first tie
      beat_cnt   <= LEN_ZERO;
      len_q      <= LEN_ZERO;
      err_len    <= 1'b0;
    end else begin
      err_len <= 1'b0;
      case (state)
        IDLE: begin
          if (m0_arvalid && m1_arvalid) begin
            grant <= ~last_grant;
            state <= ADDR;
          end else if (m0_arvalid) begin
            grant <= 1'b0;
            state <= ADDR;
          end else if (m1_arvalid) begin
            grant <= 1'b1;
            state <= ADDR;
          end else begin
            state <= IDLE;
          end
        end
        ADDR: begin
          // grant stays put until the slave accepts, whatever the other
          // master does meanwhile
          if (ar_hs) begin
            len_q    <= grant ? m1_arlen : m0_arlen;
            beat_cnt <= LEN_ZERO;
            state    <= DATA;
          end else begin
            state <= ADDR;
          end
        end
        DATA: begin
          if (r_hs) begin
            beat_cnt <= beat_cnt + LEN_ONE;
            if (s_rlast) begin
              // beat_cnt holds the zero-based index of this beat, which
              // must equal arlen for a correctly sized burst
              err_len    <= (beat_cnt != len_q);
              last_grant <= grant;
              state      <= IDLE;
            end else begin
              // the final expected beat came without rlast: burst too long
              err_len <= (beat_cnt == len_q);
              state   <= DATA;
            end
          end else begin
            state <= DATA;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// ---------------------------------------------------------------------------
// tb_axi_rd_arbiter
//
// Directed bench for axi_rd_arbiter. The bench plays the slave and both
// masters from one initial block. Inputs are driven 1 ns after the rising
// edge. Outputs are sampled a further 1 ns later, well away from the edge.
// ---------------------------------------------------------------------------
module tb_axi_rd_arbiter;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 64;
  localparam int LEN_W  = 8;

  localparam logic [ADDR_W-1:0] A0 = 32'h8000_0000;
  localparam logic [ADDR_W-1:0] A1 = 32'h4000_1000;

  logic              clk;
  logic              rst;
  logic [ADDR_W-1:0] m0_araddr, m1_araddr;
  logic [LEN_W-1:0]  m0_arlen, m1_arlen;
  logic [2:0]        m0_arsize, m1_arsize;
  logic [1:0]        m0_arburst, m1_arburst;
  logic              m0_arvalid, m1_arvalid;
  logic              m0_arready, m1_arready;
  logic [DATA_W-1:0] m0_rdata, m1_rdata;
  logic [1:0]        m0_rresp, m1_rresp;
  logic              m0_rvalid, m1_rvalid;
  logic              m0_rlast, m1_rlast;
  logic              m0_rready, m1_rready;
  logic [ADDR_W-1:0] s_araddr;
  logic [LEN_W-1:0]  s_arlen;
  logic [2:0]        s_arsize;
  logic [1:0]        s_arburst;
  logic              s_arvalid;
  logic              s_arready;
  logic [DATA_W-1:0] s_rdata;
  logic [1:0]        s_rresp;
  logic              s_rvalid;
  logic              s_rlast;
  logic              s_rready;
  logic              grant;
  logic              busy;
  logic              err_len;

  int passed = 0;
  int total  = 0;
  int fails  = 0;

  axi_rd_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst),
    .m0_araddr(m0_araddr), .m0_arlen(m0_arlen), .m0_arsize(m0_arsize),
    .m0_arburst(m0_arburst), .m0_arvalid(m0_arvalid), .m0_arready(m0_arready),
    .m0_rdata(m0_rdata), .m0_rresp(m0_rresp), .m0_rvalid(m0_rvalid),
    .m0_rlast(m0_rlast), .m0_rready(m0_rready),
    .m1_araddr(m1_araddr), .m1_arlen(m1_arlen), .m1_arsize(m1_arsize),
    .m1_arburst(m1_arburst), .m1_arvalid(m1_arvalid), .m1_arready(m1_arready),
    .m1_rdata(m1_rdata), .m1_rresp(m1_rresp), .m1_rvalid(m1_rvalid),
    .m1_rlast(m1_rlast), .m1_rready(m1_rready),
    .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arsize(s_arsize),
    .s_arburst(s_arburst), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid),
    .s_rlast(s_rlast), .s_rready(s_rready),
    .grant(grant), .busy(busy), .err_len(err_len)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case the sequence ever stalls.
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // Precondition: DUT in IDLE with the requester arvalid(s) already driven.
  // Walks IDLE -> ADDR -> DATA and checks the granted master g is the one
  // routed to the slave.
  task automatic issue(input int g, input logic [LEN_W-1:0] len);
    if (g != 0) m1_arlen = len;
    else        m0_arlen = len;
    #1;
    chk("idle_s_arvalid", s_arvalid, 1'b0);
    chk("idle_arready", m0_arready | m1_arready, 1'b0);
    tick();
    chk("addr_busy", busy, 1'b1);
    chk("addr_grant", grant, g);
    chk("addr_s_arvalid", s_arvalid, 1'b1);
    chk("addr_s_araddr", s_araddr, (g != 0) ? A1 : A0);
    chk("addr_s_arlen", s_arlen, len);
    s_arready = 1'b1;
    #1;
    chk("addr_arready_granted", (g != 0) ? m1_arready : m0_arready, 1'b1);
    chk("addr_arready_other", (g != 0) ? m0_arready : m1_arready, 1'b0);
    tick();
    s_arready = 1'b0;
    if (g != 0) m1_arvalid = 1'b0;
    else        m0_arvalid = 1'b0;
  endtask

  // One slave beat delivered with handshake, routed to master m only.
  task automatic beat(input int m, input logic [63:0] d, input logic last);
    s_rvalid = 1'b1;
    s_rdata  = d;
    s_rlast  = last;
    s_rresp  = 2'b00;
    #1;
    chk("r_valid", (m != 0) ? m1_rvalid : m0_rvalid, 1'b1);
    chk("r_data", (m != 0) ? m1_rdata : m0_rdata, d);
    chk("r_last", (m != 0) ? m1_rlast : m0_rlast, last);
    chk("r_other_valid", (m != 0) ? m0_rvalid : m1_rvalid, 1'b0);
    chk("r_other_last", (m != 0) ? m0_rlast : m1_rlast, 1'b0);
    chk("s_rready", s_rready, 1'b1);
    tick();
    s_rvalid = 1'b0;
    s_rlast  = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    m0_araddr = A0; m1_araddr = A1;
    m0_arlen = 8'd0; m1_arlen = 8'd0;
    m0_arsize = 3'd3; m1_arsize = 3'd3;
    m0_arburst = 2'b01; m1_arburst = 2'b01;
    m0_arvalid = 1'b0; m1_arvalid = 1'b0;
    m0_rready = 1'b1; m1_rready = 1'b1;
    s_arready = 1'b0; s_rvalid = 1'b0; s_rlast = 1'b0;
    s_rdata = 64'd0; s_rresp = 2'b00;
    repeat (2) tick();

    // Reset state, with stray activity on every input.
    m0_arvalid = 1'b1; m1_arvalid = 1'b1; s_rvalid = 1'b1; s_arready = 1'b1;
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_grant", grant, 1'b0);
    chk("rst_err_len", err_len, 1'b0);
    chk("rst_s_arvalid", s_arvalid, 1'b0);
    chk("rst_s_rready", s_rready, 1'b0);
    chk("rst_arready", m0_arready | m1_arready, 1'b0);
    chk("rst_rvalid", m0_rvalid | m1_rvalid, 1'b0);
    tick();
    chk("rst_busy_held", busy, 1'b0);
    m0_arvalid = 1'b0; m1_arvalid = 1'b0; s_rvalid = 1'b0; s_arready = 1'b0;
    rst = 1'b0;
    tick();

    // m0 alone, 8-beat burst.
    m0_arvalid = 1'b1;
    issue(0, 8'd7);
    for (int i = 0; i < 8; i++) beat(0, 64'h1000 + 64'(i), i == 7);
    chk("t1_busy_end", busy, 1'b0);
    chk("t1_err_len", err_len, 1'b0);

    // Stray slave beat in IDLE is not forwarded.
    s_rvalid = 1'b1; s_rlast = 1'b1;
    #1;
    chk("stray_s_rready", s_rready, 1'b0);
    chk("stray_rvalid", m0_rvalid | m1_rvalid, 1'b0);
    tick();
    chk("stray_busy", busy, 1'b0);
    s_rvalid = 1'b0; s_rlast = 1'b0;

    // Simultaneous requests after reset: m0, then m1, then m0 again.
    reset_dut();
    m0_arvalid = 1'b1; m1_arvalid = 1'b1;
    issue(0, 8'd3);
    for (int i = 0; i < 4; i++) beat(0, 64'h2000 + 64'(i), i == 3);
    chk("t2_busy_gap", busy, 1'b0);
    issue(1, 8'd1);
    for (int i = 0; i < 2; i++) beat(1, 64'h2100 + 64'(i), i == 1);
    m0_arvalid = 1'b1; m1_arvalid = 1'b1;
    issue(0, 8'd0);
    beat(0, 64'h2200, 1'b1);
    issue(1, 8'd0);
    beat(1, 64'h2300, 1'b1);

    // m1 requests during beat 3 of an m0 burst and must wait.
    m0_arvalid = 1'b1;
    issue(0, 8'd7);
    for (int i = 0; i < 8; i++) begin
      if (i == 3) m1_arvalid = 1'b1;
      beat(0, 64'h3000 + 64'(i), i == 7);
      if (i >= 3 && i < 7) chk("t3_m1_arready_wait", m1_arready, 1'b0);
    end
    chk("t3_busy_gap", busy, 1'b0);
    issue(1, 8'd1);
    for (int i = 0; i < 2; i++) beat(1, 64'h3100 + 64'(i), i == 1);

    // m0 back-pressures for two cycles mid-burst.
    m0_arvalid = 1'b1;
    issue(0, 8'd7);
    for (int i = 0; i < 3; i++) beat(0, 64'h4000 + 64'(i), 1'b0);
    s_rvalid = 1'b1; s_rdata = 64'h4003; m0_rready = 1'b0;
    #1;
    chk("t4_stall_s_rready", s_rready, 1'b0);
    chk("t4_stall_rvalid", m0_rvalid, 1'b1);
    tick();
    chk("t4_stall2_s_rready", s_rready, 1'b0);
    tick();
    m0_rready = 1'b1;
    for (int i = 3; i < 8; i++) beat(0, 64'h4000 + 64'(i), i == 7);
    chk("t4_busy_end", busy, 1'b0);
    chk("t4_err_len", err_len, 1'b0);

    // Early rlast on the fifth beat of an arlen=7 burst.
    m0_arvalid = 1'b1;
    issue(0, 8'd7);
    for (int i = 0; i < 5; i++) beat(0, 64'h5000 + 64'(i), i == 4);
    chk("t5_busy_end", busy, 1'b0);
    chk("t5_err_pulse", err_len, 1'b1);
    tick();
    chk("t5_err_clear", err_len, 1'b0);
    m0_arvalid = 1'b1;
    issue(0, 8'd1);
    for (int i = 0; i < 2; i++) beat(0, 64'h5100 + 64'(i), i == 1);
    chk("t5_next_err_len", err_len, 1'b0);

    // Reset at beat 4: last_grant returns to 1, so m0 wins the next tie.
    m0_arvalid = 1'b1;
    issue(0, 8'd7);
    for (int i = 0; i < 4; i++) beat(0, 64'h6000 + 64'(i), 1'b0);
    s_rvalid = 1'b1; s_rdata = 64'h6004; rst = 1'b1;
    #1;
    chk("t6_rst_rvalid", m0_rvalid, 1'b0);
    chk("t6_rst_s_rready", s_rready, 1'b0);
    tick();
    chk("t6_busy", busy, 1'b0);
    chk("t6_grant", grant, 1'b0);
    chk("t6_err_len", err_len, 1'b0);
    chk("t6_s_arvalid", s_arvalid, 1'b0);
    rst = 1'b0; s_rvalid = 1'b0;
    m0_arvalid = 1'b1; m1_arvalid = 1'b1;
    issue(0, 8'd1);
    for (int i = 0; i < 2; i++) beat(0, 64'h6100 + 64'(i), i == 1);
    issue(1, 8'd1);
    for (int i = 0; i < 2; i++) beat(1, 64'h6200 + 64'(i), i == 1);
    chk("t6_busy_end", busy, 1'b0);
    chk("t6_err_end", err_len, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
